// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI test-pattern source: pattern modes,
// colour-bar table and raster-width helper.
package hdmi_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  // {R,G,B} on/off flags, bar 0 at the left edge of the active line
  localparam logic [2:0] BAR_TABLE [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic int total_width(int sync_w, int back_w, int valid_w, int front_w);
    return sync_w + back_w + valid_w + front_w;
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Horizontal/vertical raster counters with sync and active-area decode.
// Counters hold at zero while en is low so a re-enable starts a fresh frame.
module vga_timing_core
  import hdmi_pkg::*;
#(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_h,
  output logic [CNT_W-1:0] cnt_v,
  output logic             h_act,
  output logic             v_act,
  output logic             hs_raw,
  output logic             vs_raw
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(total_width(H_SYNC, H_BACK, H_VALID, H_FRONT) - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(total_width(V_SYNC, V_BACK, V_VALID, V_FRONT) - 1);
  localparam logic [CNT_W-1:0] H_SYNC_W = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_W = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + V_VALID);

  // NOTE: non-blocking assignments so both counters update from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (!en) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
    end else begin
      cnt_h <= cnt_h + 1'b1;
    end
  end

  assign h_act  = (cnt_h >= H_ACT_LO) && (cnt_h < H_ACT_HI);
  assign v_act  = (cnt_v >= V_ACT_LO) && (cnt_v < V_ACT_HI);
  assign hs_raw = cnt_h < H_SYNC_W;
  assign vs_raw = cnt_v < V_SYNC_W;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Parametrised video timing and test-pattern source feeding the TMDS encoder.
// Every output is registered once from the same counter snapshot, so they stay aligned.
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_VALID     = 640,
  parameter int H_FRONT     = 16,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_VALID     = 480,
  parameter int V_FRONT     = 10,
  parameter int SYNC_POL    = 1,
  parameter int COLOR_DEPTH = 8,
  parameter int CHECK_LOG2  = 5
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [3*COLOR_DEPTH-1:0] solid_rgb,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic [3*COLOR_DEPTH-1:0] rgb,
  output logic [10:0]              pix_x,
  output logic [10:0]              pix_y,
  output logic                     frame_start
);

  localparam int               RGB_W    = 3 * COLOR_DEPTH;
  localparam logic             SYNC_ACT = (SYNC_POL != 0);
  localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_VALID / 8 - 1);

  logic [CNT_W-1:0] cnt_h;
  logic [CNT_W-1:0] cnt_v;
  logic             h_act;
  logic             v_act;
  logic             hs_raw;
  logic             vs_raw;

  vga_timing_core #(
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .H_VALID (H_VALID),
    .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_VALID (V_VALID),
    .V_FRONT (V_FRONT)
  ) u_timing (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .cnt_h     (cnt_h),
    .cnt_v     (cnt_v),
    .h_act     (h_act),
    .v_act     (v_act),
    .hs_raw    (hs_raw),
    .vs_raw    (vs_raw)
  );

  mode_e            mode_q;
  logic [2:0]       bar_idx;
  logic [CNT_W-1:0] bar_cnt;
  logic             frame_origin;
  logic             act;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  logic [2:0]       bar_flags;
  logic [RGB_W-1:0] rgb_next;

  assign frame_origin = (cnt_h == '0) && (cnt_v == '0);
  assign act          = h_act && v_act;
  assign x_next       = act ? cnt_h - H_START : '0;
  assign y_next       = act ? cnt_v - V_START : '0;
  assign bar_flags    = BAR_TABLE[bar_idx];

  // Bar tracking runs in step with cnt_h: at the first active pixel both are zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q  <= MODE_BARS;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (!en) begin
      mode_q  <= MODE_BARS;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      if (frame_origin) begin
        mode_q <= mode_e'(mode);
      end
      if (!h_act) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

  // NOTE: default assignment first so no path through the mux infers a latch.
  always_comb begin
    rgb_next = '0;
    if (act) begin
      case (mode_q)
        MODE_BARS:    rgb_next = {{COLOR_DEPTH{bar_flags[2]}},
                                  {COLOR_DEPTH{bar_flags[1]}},
                                  {COLOR_DEPTH{bar_flags[0]}}};
        MODE_RAMP:    rgb_next = {3{x_next[COLOR_DEPTH-1:0]}};
        MODE_CHECKER: rgb_next = (x_next[CHECK_LOG2] ^ y_next[CHECK_LOG2]) ? '1 : '0;
        MODE_SOLID:   rgb_next = solid_rgb;
        default:      rgb_next = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      de          <= 1'b0;
      rgb         <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      de          <= 1'b0;
      rgb         <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~(hs_raw ^ SYNC_ACT);
      vsync       <= ~(vs_raw ^ SYNC_ACT);
      de          <= act;
      rgb         <= rgb_next;
      pix_x       <= x_next;
      pix_y       <= y_next;
      frame_start <= frame_origin;
    end
  end

endmodule
